// File: rtl/fifo_pkt_pkg.sv
// Shared types and constants for the FIFO packet writer.
// Framing: SYNC byte, payload bytes MSB-first, then an XOR checksum of the payload.
package fifo_pkt_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LOAD = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  // A byte count of 0 on the last word means a full word.
  function automatic logic [2:0] byte_count(input logic last, input logic [1:0] bytes);
    if (!last || bytes == 2'd0) return 3'd4;
    return {1'b0, bytes};
  endfunction

endpackage

// File: rtl/fifo_wr_serializer.sv
// 32->8 shift register for one source word, tracking byte index and word length.
module fifo_wr_serializer
  import fifo_pkt_pkg::*;
(
  input  logic              Reset_n,
  input  logic              wr_clk,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic [1:0]        load_bytes,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte,
  output logic              last_q
);

  logic [WORD_W-1:0] shreg;
  logic [1:0]        idx;
  logic [2:0]        nb;

  always_ff @(posedge wr_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg  <= '0;
      idx    <= '0;
      nb     <= 3'd4;
      last_q <= 1'b0;
    end else if (load) begin
      shreg  <= load_data;
      idx    <= 2'd0;
      nb     <= byte_count(load_last, load_bytes);
      last_q <= load_last;
    end else if (shift) begin
      shreg <= {shreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      idx   <= idx + 2'd1;
    end
  end

  assign byte_out  = shreg[WORD_W-1 -: BYTE_W];
  assign last_byte = ({1'b0, idx} == (nb - 3'd1));

endmodule

// File: rtl/fifo_pkt_writer.sv
// Frames source words into SYNC/payload/checksum bytes and pushes them into the async FIFO.
//   state | meaning
//   IDLE  | waiting for a source word and FIFO room to start a packet
//   SYNC  | emitting the header byte
//   LOAD  | accepting the next source word (no push)
//   DATA  | emitting payload bytes MSB-first
//   CSUM  | emitting the XOR checksum, then counting the packet
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter bit         HALF_GATE = 1'b1
) (
  input  logic        Reset_n,
  input  logic        wr_clk,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        wr_enable,
  output logic [7:0]  wr_data,
  input  logic        wr_full,
  input  logic        wr_half,
  output logic        busy,
  output logic        pkt_done,
  output logic [15:0] pkt_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  csum;
  logic        emitting;
  logic        push;
  logic        csum_clr;
  logic        ser_load;
  logic        ser_shift;
  logic [7:0]  ser_byte;
  logic        ser_last_byte;
  logic        ser_last_q;
  logic        start_ok;

  fifo_wr_serializer u_ser (
    .Reset_n    (Reset_n),
    .wr_clk     (wr_clk),
    .load       (ser_load),
    .shift      (ser_shift),
    .load_data  (in_data),
    .load_last  (in_last),
    .load_bytes (in_bytes),
    .byte_out   (ser_byte),
    .last_byte  (ser_last_byte),
    .last_q     (ser_last_q)
  );

  // wr_half only matters when deciding to open a new packet.
  assign start_ok = in_valid && (!wr_half || !HALF_GATE) && !wr_full;

  always_ff @(posedge wr_clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emitting  = 1'b0;
    wr_data   = 8'h00;
    in_ready  = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    csum_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SYNC;
          csum_clr  = 1'b1;
        end
      end
      ST_SYNC: begin
        emitting = 1'b1;
        wr_data  = SYNC_BYTE;
        if (!wr_full) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ser_load  = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        emitting = 1'b1;
        wr_data  = ser_byte;
        if (!wr_full) begin
          ser_shift = 1'b1;
          if (ser_last_byte) state_nxt = ser_last_q ? ST_CSUM : ST_LOAD;
        end
      end
      ST_CSUM: begin
        emitting = 1'b1;
        wr_data  = csum;
        if (!wr_full) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign push      = emitting && !wr_full;
  assign wr_enable = push;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge wr_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      csum     <= 8'h00;
      pkt_done <= 1'b0;
      pkt_cnt  <= 16'h0000;
    end else begin
      pkt_done <= (state == ST_CSUM) && push;
      if (csum_clr)
        csum <= 8'h00;
      else if ((state == ST_DATA) && push)
        csum <= csum ^ ser_byte;
      if ((state == ST_CSUM) && push)
        pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed bench for fifo_pkt_writer: expected bytes are queued at stimulus time
// and a negedge monitor pops and compares every FIFO push.
module tb_fifo_pkt_writer;

  logic        Reset_n;
  logic        wr_clk;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;
  logic        wr_enable;
  logic [7:0]  wr_data;
  logic        wr_full;
  logic        wr_half;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_cnt;

  fifo_pkt_writer dut (
    .Reset_n   (Reset_n),
    .wr_clk    (wr_clk),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .wr_half   (wr_half),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_cnt   (pkt_cnt)
  );

  typedef struct {
    logic [7:0] b;
    bit         sync;
    bit         csum;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_csum_cyc = -1;
  bit   b2b_mode = 0;
  bit   stall_seen = 0;
  bit   rst_seen = 0;

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [7:0] b, input bit s, input bit c);
    exp_t e;
    e.b = b; e.sync = s; e.csum = c;
    exp_q.push_back(e);
  endfunction

  always @(negedge wr_clk) begin
    exp_t e;
    if (pkt_done) done_cnt++;
    if (Reset_n && wr_enable) begin
      check("push while full", {31'd0, wr_full}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected push: got %0h expected none", wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", {24'd0, wr_data}, {24'd0, e.b});
        if (e.sync && b2b_mode && last_csum_cyc >= 0)
          check("b2b csum-to-sync gap", cyc - last_csum_cyc, 32'd2);
        if (e.csum) last_csum_cyc = cyc;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nbytes,
                           input bit first, input logic [7:0] ecs);
    int  n;
    bit  ok;
    if (first) push_exp(8'hA5, 1'b1, 1'b0);
    n = (last && nbytes != 2'd0) ? int'(nbytes) : 4;
    for (int i = 0; i < n; i++) push_exp(d[31-8*i -: 8], 1'b0, 1'b0);
    if (last) push_exp(ecs, 1'b0, 1'b1);
    in_data  = d;
    in_last  = last;
    in_bytes = nbytes;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge wr_clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: got in_ready=0 expected 1 for word %0h", d);
    end else begin
      @(posedge wr_clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge wr_clk);
    check("queue drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge wr_clk);
  endtask

  initial begin
    Reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = 2'd0;
    wr_full  = 1'b0;
    wr_half  = 1'b0;
    repeat (3) @(negedge wr_clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset wr_enable", {31'd0, wr_enable}, 32'd0);
    check("reset wr_data", {24'd0, wr_data}, 32'd0);
    check("reset pkt_done", {31'd0, pkt_done}, 32'd0);
    check("reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    @(posedge wr_clk); #1 Reset_n = 1'b1;

    // single full word: checksum 11^22^33^44 = 44
    send_word(32'h11223344, 1'b1, 2'd0, 1'b1, 8'h44);
    drain();
    check("t1 pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("t1 done pulses", done_cnt, 32'd1);

    // two words, short tail, with a 5-cycle full stall on byte AD
    fork
      begin
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
          @(negedge wr_clk);
          if (wr_enable && wr_data == 8'hDE) got = 1;
        end
        if (got) begin
          @(posedge wr_clk); #1 wr_full = 1'b1;
          repeat (5) begin
            @(negedge wr_clk);
            check("stall wr_enable", {31'd0, wr_enable}, 32'd0);
            check("stall wr_data", {24'd0, wr_data}, 32'h0000_00AD);
          end
          @(posedge wr_clk); #1 wr_full = 1'b0;
          stall_seen = 1;
        end
      end
    join_none
    send_word(32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 8'h00);
    send_word(32'h01020304, 1'b1, 2'd2, 1'b0, 8'h21);
    drain();
    check("t2 stall applied", {31'd0, stall_seen}, 32'd1);
    check("t2 pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    check("t2 done pulses", done_cnt, 32'd2);

    // half gating: held off while wr_half=1, then starts; later wr_half is ignored
    wr_half  = 1'b1;
    in_data  = 32'hCAFEF00D;
    in_last  = 1'b1;
    in_bytes = 2'd0;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge wr_clk);
      check("half busy", {31'd0, busy}, 32'd0);
      check("half wr_enable", {31'd0, wr_enable}, 32'd0);
    end
    push_exp(8'hA5, 1'b1, 1'b0);
    @(posedge wr_clk); #1 wr_half = 1'b0;
    @(negedge wr_clk);
    check("half still idle", {31'd0, busy}, 32'd0);
    @(negedge wr_clk);
    check("half sync busy", {31'd0, busy}, 32'd1);
    check("half sync wr_enable", {31'd0, wr_enable}, 32'd1);
    check("half sync wr_data", {24'd0, wr_data}, 32'h0000_00A5);
    wr_half = 1'b1;
    send_word(32'hCAFEF00D, 1'b1, 2'd0, 1'b0, 8'hC9);
    drain();
    wr_half = 1'b0;
    check("t3 pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    check("t3 done pulses", done_cnt, 32'd3);

    // async reset right after byte BE
    fork
      begin
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
          @(negedge wr_clk);
          if (wr_enable && wr_data == 8'hBE) got = 1;
        end
        if (got) begin
          @(posedge wr_clk); #1 Reset_n = 1'b0;
          rst_seen = 1;
        end
      end
    join_none
    send_word(32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 8'h00);
    for (int k = 0; k < 100 && !rst_seen; k++) @(negedge wr_clk);
    check("reset issued", {31'd0, rst_seen}, 32'd1);
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst wr_enable", {31'd0, wr_enable}, 32'd0);
    check("mid-rst wr_data", {24'd0, wr_data}, 32'd0);
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    check("mid-rst pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("truncated bytes left", exp_q.size(), 32'd1);
    exp_q.delete();
    @(posedge wr_clk); #1 Reset_n = 1'b1;
    send_word(32'h0A0B0C0D, 1'b1, 2'd0, 1'b1, 8'h00);
    drain();
    check("t4 pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("t4 done pulses", done_cnt, 32'd4);

    // back-to-back single-word packets with 1, 2 and 3 valid bytes
    b2b_mode = 1;
    last_csum_cyc = -1;
    send_word(32'h01000000, 1'b1, 2'd1, 1'b1, 8'h01);
    send_word(32'h55AA0000, 1'b1, 2'd2, 1'b1, 8'hFF);
    send_word(32'h12345678, 1'b1, 2'd3, 1'b1, 8'h70);
    drain();
    b2b_mode = 0;
    check("t5 pkt_cnt", {16'd0, pkt_cnt}, 32'd4);
    check("t5 done pulses", done_cnt, 32'd7);
    check("t5 idle at end", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
